// File: rtl/acc_reg.sv
// acc_reg: 33-bit accumulator register with load, logical right shift and
// modulo-2^33 add, applied in fixed priority Rst > Load > Sh > Ad > hold.
// Saidas is the register itself, with no combinational path from the inputs.
// Optional feature: define ACC_ZERO_FLAG_EN to add the Zero output, which is
// high whenever the accumulator holds 0.
module acc_reg (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Load,
    input  logic        Sh,
    input  logic        Ad,
    input  logic [32:0] Entradas,
    output logic [32:0] Saidas
`ifdef ACC_ZERO_FLAG_EN
    ,
    output logic        Zero
`endif
);

    localparam int W = 33;

    logic [W-1:0] acc_reg;
    logic [W-1:0] acc_next;
    logic [W-1:0] shifted;
    logic [W-1:0] summed;

    // Logical right shift: each bit takes its upper neighbour, and the MSB is filled with 0.
    generate
        for (genvar gi = 0; gi < W - 1; gi++) begin : g_shift
            assign shifted[gi] = acc_reg[gi+1];
        end
    endgenerate
    assign shifted[W-1] = 1'b0;

    // The carry out of the MSB is intentionally dropped (wraps modulo 2^33).
    assign summed = acc_reg + Entradas;

    // Priority select of the next value; Entradas only matters for Load and Ad.
    always_comb begin
        acc_next = acc_reg;
        if (Load) begin
            acc_next = Entradas;
        end else if (Sh) begin
            acc_next = shifted;
        end else if (Ad) begin
            acc_next = summed;
        end
    end

    // Accumulator register; synchronous reset overrides every other control.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            acc_reg <= '0;
        end else begin
            acc_reg <= acc_next;
        end
    end

    assign Saidas = acc_reg;

`ifdef ACC_ZERO_FLAG_EN
    assign Zero = (acc_reg == '0);
`endif

endmodule

// File: tb/tb_acc_reg.sv
// tb_acc_reg: directed bench for acc_reg. A behavioural model (plain integer
// arithmetic) is compared against Saidas (and Zero, when ACC_ZERO_FLAG_EN is
// defined) on every falling edge after the first reset. Hand-computed literals
// pin the model itself.
module tb_acc_reg;

    logic        Clk;
    logic        Rst;
    logic        Load;
    logic        Sh;
    logic        Ad;
    logic [32:0] Entradas;
    logic [32:0] Saidas;
`ifdef ACC_ZERO_FLAG_EN
    logic        Zero;
`endif

    int          n_compared = 0;
    int          n_mismatched = 0;
    logic [63:0] model_acc = 64'd0;
    bit          model_valid = 1'b0;

    acc_reg dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Load     (Load),
        .Sh       (Sh),
        .Ad       (Ad),
        .Entradas (Entradas),
        .Saidas   (Saidas)
`ifdef ACC_ZERO_FLAG_EN
        ,
        .Zero     (Zero)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Model: the arithmetic meaning of each operation, applied in priority order.
    always @(posedge Clk) begin
        if (Rst) begin
            model_acc = 64'd0;
            model_valid = 1'b1;
        end else if (Load) begin
            model_acc = {31'd0, Entradas};
        end else if (Sh) begin
            model_acc = model_acc / 64'd2;
        end else if (Ad) begin
            model_acc = (model_acc + {31'd0, Entradas}) % 64'h2_0000_0000;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge Clk) begin
        if (model_valid) begin
            n_compared++;
            if ({31'd0, Saidas} !== model_acc) begin
                n_mismatched++;
                $display("FAIL model_saidas t=%0t: got %h want %h", $time, Saidas, model_acc[32:0]);
            end
`ifdef ACC_ZERO_FLAG_EN
            n_compared++;
            if (Zero !== (model_acc == 64'd0)) begin
                n_mismatched++;
                $display("FAIL model_zero t=%0t: got %b want %b", $time, Zero, (model_acc == 64'd0));
            end
`endif
        end
    end

    task automatic check(input string name, input logic [32:0] want);
        n_compared++;
        if (Saidas !== want) begin
            n_mismatched++;
            $display("FAIL %s: got %h want %h", name, Saidas, want);
        end
`ifdef ACC_ZERO_FLAG_EN
        n_compared++;
        if (Zero !== (want == 33'd0)) begin
            n_mismatched++;
            $display("FAIL %s_zero: got %b want %b", name, Zero, (want == 33'd0));
        end
`endif
    endtask

    // Apply one set of controls for exactly one rising edge, then return at the falling edge.
    task automatic step(input logic r, input logic l, input logic s, input logic a,
                        input logic [32:0] e);
        Rst = r;
        Load = l;
        Sh = s;
        Ad = a;
        Entradas = e;
        @(posedge Clk);
        @(negedge Clk);
        $display("txn rst=%b load=%b sh=%b ad=%b in=%h -> out=%h", r, l, s, a, e, Saidas);
    endtask

    initial begin
        Rst = 1'b1;
        Load = 1'b0;
        Sh = 1'b0;
        Ad = 1'b0;
        Entradas = '0;

        step(1, 0, 0, 0, 33'd0);              check("reset", 33'd0);
        step(0, 1, 0, 0, 33'd7);              check("load7", 33'd7);
        step(0, 0, 1, 0, 33'd1);              check("shift7", 33'd3);
        step(0, 0, 0, 1, 33'd200);            check("add200", 33'd203);
        step(1, 0, 0, 1, 33'd5);              check("rst_mid_add", 33'd0);
        step(0, 1, 0, 0, 33'd77);             check("load77", 33'd77);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 33'h1_2345_6789);
            check("idle_hold", 33'd77);
        end
        step(0, 1, 0, 0, 33'h1_FFFF_FFFF);    check("load_max", 33'h1_FFFF_FFFF);
        step(0, 0, 0, 1, 33'd1);              check("add_wrap", 33'd0);
        step(0, 1, 0, 0, 33'h1_0000_0000);    check("load_msb", 33'h1_0000_0000);
        step(0, 0, 1, 0, 33'd0);              check("shift_msb", 33'h0_8000_0000);
        step(0, 0, 0, 1, 33'h1_8000_0005);    check("add_carry", 33'h0_0000_0005);
        step(0, 1, 0, 0, 33'd9);              check("load9", 33'd9);
        step(0, 1, 1, 1, 33'd5);              check("prio_load", 33'd5);
        step(0, 1, 0, 0, 33'd8);              check("load8", 33'd8);
        step(0, 0, 1, 1, 33'd100);            check("prio_shift", 33'd4);

        // Reset pulse entirely between rising edges must not touch the register.
        Load = 1'b0;
        Sh = 1'b0;
        Ad = 1'b0;
        #2 Rst = 1'b1;
        #1 check("rst_glitch_now", 33'd4);
        #1 Rst = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        check("rst_glitch_after", 33'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
